alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU interface (alu_a, alu_b, 4-bit ALU control code) from a raw RV32I instruction and register-file operands.
- Performs opcode/funct decode, immediate generation and operand muxing.
- Registers the result in a valid/ready pipeline slot backed by a one-entry skid buffer, so the execute stage can stall without a combinational ready path.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  drops all held entries.
- in_valid_i  in  1  upstream instruction valid.
- in_ready_o  in/out: out  1  stage can accept; registered, equals "skid entry empty".
- instr_i  in  32  instruction word.
- pc_i  in  32  instruction PC.
- rs1_data_i  in  32  rs1 value.
- rs2_data_i  in  32  rs2 value.
- out_valid_o  out  1  ALU operands valid.
- out_ready_i  in  1  execute stage accepts.
- alu_a_o  out  32  ALU operand A.
- alu_b_o  out  32  ALU operand B.
- aluctrl_ctrl_o  out  4  ALU op.
- rd_o  out  5  destination register.
- rd_we_o  out  1  writeback enable.
- illegal_o  out  1  undecodable instruction.

Behaviour:
- ALU codes: ADD 0000, SUB 1000, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101. For OP/OP-IMM the code is {funct7[5], funct3}, with bit 3 forced to 0 except SUB and SRA(I).
- Immediates are sign-extended per I/S/U formats.
- OP (0110011): a=rs1, b=rs2.
  - funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - Otherwise illegal.
- OP-IMM (0010011): a=rs1, b=I-imm.
  - Bit 3 of the code is 0 except funct3=101 with imm[11:5]=0100000, which gives SRA.
  - funct3=001 requires imm[11:5]=0.
  - funct3=101 requires imm[11:5] to be 0000000 or 0100000.
  - Otherwise illegal.
- LUI: a=0, b=U-imm, ADD.
- AUIPC: a=pc, b=U-imm, ADD.
- LOAD: a=rs1, b=I-imm, ADD.
- STORE: a=rs1, b=S-imm, ADD, rd_we=0.
- BRANCH: a=rs1, b=rs2.
  - funct3 000/001 give SUB; 100/101 give SLT; 110/111 give SLTU.
  - 010/011 are illegal.
  - rd_we=0.
- JAL, and JALR with funct3=000: a=pc, b=32'd4, ADD, rd_we=1. JALR with funct3≠000 is illegal.
- Any other opcode is illegal.
- Illegal output: a=b=0, ctrl=0000, rd_we=0, illegal=1; rd still carries instr[11:7].
- rd_we is forced to 0 when rd=x0.
- Handshake:
  - Input transfers on in_valid_i & in_ready_o.
  - Output transfers on out_valid_o & out_ready_i.
  - Latency is 1 cycle from input transfer to out_valid_o when the output slot is empty or draining.
- Stall: if the output slot is full and not draining, an accepted instruction goes to the skid entry and in_ready_o falls next cycle. When the output drains, the skid entry moves to the output and in_ready_o rises next cycle.
- Output ordering is strictly FIFO.
- All output fields are held stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous input accept and output drain with the skid entry empty: the new entry replaces the output and out_valid_o stays 1.
- flush_i: next cycle out_valid_o=0, skid entry empty, in_ready_o=1. An input offered in the flush cycle is dropped. Flush has priority over all other events.
- Reset (rst_n=0 at a clock edge, including mid-stall):
  - out_valid_o=0, in_ready_o=1, skid entry cleared.
  - alu_a_o=alu_b_o=0, aluctrl_ctrl_o=0000, rd_o=0, rd_we_o=0, illegal_o=0.

Test Plan:
- ADD x3,x1,x2: instr=0x002081B3, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, a=5, b=7, ctrl=0000, rd=3, rd_we=1, illegal=0.
- SRAI x5,x6,3 (instr 0x40335293), rs1=0x80000000 → b=0x00000403, ctrl=1101, rd=5. LUI x1,0x12345 (0x123450B7) → a=0, b=0x12345000, ctrl=0000.
- BLTU x1,x2 (funct3=110), rs1=1, rs2=2 → ctrl=0011, rd_we=0. Instr 0x00000000 → illegal=1, a=b=0, rd_we=0. OP with funct7=0100000, funct3=111 → illegal=1.
- Backpressure: hold out_ready=0, send instructions A then B on consecutive cycles.
  - in_ready_o=0 on the cycle after B is accepted.
  - A is held stable on the outputs.
  - Release out_ready → A, then B, each on one cycle; in_ready_o returns to 1.
- Flush with both entries full → next cycle out_valid=0, in_ready=1; the input offered in the flush cycle never appears.
- Assert rst_n=0 for 1 cycle mid-stall → all outputs at reset values next cycle, in_ready=1; the first instruction after reset is emitted normally.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage_if
// Description : Handshake and operand bus between the decode side, the
//               ALU issue stage and the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);

  // Pipeline control
  logic            flush_i;

  // Upstream (decode/register-read) side
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;

  // Downstream (execute) side
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [3:0]      aluctrl_ctrl_o;
  logic [4:0]      rd_o;
  logic            rd_we_o;
  logic            illegal_o;

  // Issue stage view
  modport slave (
    input  flush_i,
    input  in_valid_i,
    output in_ready_o,
    input  instr_i,
    input  pc_i,
    input  rs1_data_i,
    input  rs2_data_i,
    output out_valid_o,
    input  out_ready_i,
    output alu_a_o,
    output alu_b_o,
    output aluctrl_ctrl_o,
    output rd_o,
    output rd_we_o,
    output illegal_o
  );

  // Surrounding pipeline view (drives instructions, consumes operands)
  modport master (
    output flush_i,
    output in_valid_i,
    input  in_ready_o,
    output instr_i,
    output pc_i,
    output rs1_data_i,
    output rs2_data_i,
    input  out_valid_o,
    output out_ready_i,
    input  alu_a_o,
    input  alu_b_o,
    input  aluctrl_ctrl_o,
    input  rd_o,
    input  rd_we_o,
    input  illegal_o
  );

endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : RV32I ID/EX stage. Decodes the instruction, builds ALU
//               operands and control code, and holds the result in an output
//               slot backed by a one-entry skid buffer so that in_ready_o has
//               no combinational path from out_ready_i.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input wire               clk,
  input wire               rst_n,
  alu_issue_stage_if.slave bus
);

  // --------------------------------------------------------------------------
  // Opcodes and ALU control codes
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b1000;
  localparam logic [3:0] c_alu_slt  = 4'b0010;
  localparam logic [3:0] c_alu_sltu = 4'b0011;

  localparam logic [6:0] c_funct7_alt = 7'b0100000;

  // One pipeline entry: everything the execute stage consumes
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            we;
    logic            ill;
  } entry_t;

  // --------------------------------------------------------------------------
  // Instruction fields and immediates
  // --------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];
  assign rd_idx = bus.instr_i[11:7];
  assign imm_i  = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
  assign imm_s  = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:25], bus.instr_i[11:7]};
  assign imm_u  = {bus.instr_i[31:12], 12'h000};

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  entry_t dec;
  logic   dec_legal;
  logic   dec_writes;

  // Decode the incoming instruction into ALU operands, control code and rd
  always_comb begin
    dec        = '0;
    dec.rd     = rd_idx;
    dec_legal  = 1'b1;
    dec_writes = 1'b0;

    case (opcode)
      c_opc_op: begin
        dec.a      = bus.rs1_data_i;
        dec.b      = bus.rs2_data_i;
        dec_writes = 1'b1;
        // Only SUB and SRA may use the alternate funct7, so once legality
        // holds the raw {funct7[5], funct3} is already the right code.
        dec.ctrl   = {funct7[5], funct3};
        dec_legal  = (funct7 == 7'b0) ||
                     ((funct7 == c_funct7_alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end

      c_opc_opimm: begin
        dec.a      = bus.rs1_data_i;
        dec.b      = imm_i;
        dec_writes = 1'b1;
        dec.ctrl   = {1'b0, funct3};
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == 7'b0);
        end else if (funct3 == 3'b101) begin
          dec_legal   = (funct7 == 7'b0) || (funct7 == c_funct7_alt);
          dec.ctrl[3] = (funct7 == c_funct7_alt);
        end
      end

      c_opc_lui: begin
        dec.a      = '0;
        dec.b      = imm_u;
        dec.ctrl   = c_alu_add;
        dec_writes = 1'b1;
      end

      c_opc_auipc: begin
        dec.a      = bus.pc_i;
        dec.b      = imm_u;
        dec.ctrl   = c_alu_add;
        dec_writes = 1'b1;
      end

      c_opc_load: begin
        dec.a      = bus.rs1_data_i;
        dec.b      = imm_i;
        dec.ctrl   = c_alu_add;
        dec_writes = 1'b1;
      end

      c_opc_store: begin
        dec.a    = bus.rs1_data_i;
        dec.b    = imm_s;
        dec.ctrl = c_alu_add;
      end

      c_opc_branch: begin
        dec.a = bus.rs1_data_i;
        dec.b = bus.rs2_data_i;
        // Pairs of funct3 share a compare: EQ/NE, LT/GE, LTU/GEU
        case (funct3[2:1])
          2'b00:   dec.ctrl  = c_alu_sub;
          2'b01:   dec_legal = 1'b0;
          2'b10:   dec.ctrl  = c_alu_slt;
          default: dec.ctrl  = c_alu_sltu;
        endcase
      end

      c_opc_jal: begin
        dec.a      = bus.pc_i;
        dec.b      = XLEN'(4);
        dec.ctrl   = c_alu_add;
        dec_writes = 1'b1;
      end

      c_opc_jalr: begin
        dec.a      = bus.pc_i;
        dec.b      = XLEN'(4);
        dec.ctrl   = c_alu_add;
        dec_writes = 1'b1;
        dec_legal  = (funct3 == 3'b000);
      end

      default: begin
        dec_legal = 1'b0;
      end
    endcase

    // Illegal instructions present neutral operands but keep rd for tracing
    if (!dec_legal) begin
      dec.a      = '0;
      dec.b      = '0;
      dec.ctrl   = c_alu_add;
      dec_writes = 1'b0;
    end

    dec.we  = dec_writes && (rd_idx != 5'd0);
    dec.ill = !dec_legal;
  end

  // --------------------------------------------------------------------------
  // Output slot and skid entry
  // --------------------------------------------------------------------------
  entry_t out_q;
  entry_t out_d;
  logic   out_valid_q;
  logic   out_valid_d;
  entry_t skid_q;
  entry_t skid_d;
  logic   skid_valid_q;
  logic   skid_valid_d;

  logic   accept;
  logic   slot_free;

  // The upstream sees ready whenever the skid entry is empty; an accept while
  // the output slot is blocked lands in the skid entry.
  assign accept    = bus.in_valid_i && !skid_valid_q;
  assign slot_free = !out_valid_q || bus.out_ready_i;

  // Next-state for the two-entry FIFO; flush overrides every other event
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (bus.flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        // Older skid entry goes first; accept is impossible in this state
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all taken straight from flops
  // --------------------------------------------------------------------------
  assign bus.in_ready_o     = !skid_valid_q;
  assign bus.out_valid_o    = out_valid_q;
  assign bus.alu_a_o        = out_q.a;
  assign bus.alu_b_o        = out_q.b;
  assign bus.aluctrl_ctrl_o = out_q.ctrl;
  assign bus.rd_o           = out_q.rd;
  assign bus.rd_we_o        = out_q.we;
  assign bus.illegal_o      = out_q.ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage: directed vectors
//               followed by randomized traffic against a mnemonic-level
//               reference model and a FIFO scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  bit   was_rst;

  string op_names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] code_of(input string m);
    case (m)
      "ADD":   return 4'b0000;
      "SUB":   return 4'b1000;
      "SLT":   return 4'b0010;
      "SLTU":  return 4'b0011;
      "XOR":   return 4'b0100;
      "OR":    return 4'b0110;
      "AND":   return 4'b0111;
      "SLL":   return 4'b0001;
      "SRL":   return 4'b0101;
      "SRA":   return 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference: classify the instruction by mnemonic, then look up the code
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t  e;
    string m;
    bit    ok;
    bit    wr;
    int    f3;
    int    f7;
    int    si;
    int    ss;
    logic [31:0] u;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    si = int'(ins[31:20]);
    if (si >= 2048) si -= 4096;
    ss = f7 * 32 + int'(ins[11:7]);
    if (ss >= 2048) ss -= 4096;
    u  = 32'(ins[31:12]) * 32'd4096;
    ok = 1'b1;
    wr = 1'b1;
    m  = "ADD";
    e.a = 32'd0;
    e.b = 32'd0;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2;
        if (f7 == 0) m = op_names[f3];
        else if (f7 == 32 && f3 == 0) m = "SUB";
        else if (f7 == 32 && f3 == 5) m = "SRA";
        else ok = 1'b0;
      end
      7'h13: begin
        e.a = r1; e.b = 32'(si);
        m = op_names[f3];
        if (f3 == 1 && f7 != 0) ok = 1'b0;
        if (f3 == 5) begin
          if (f7 == 32) m = "SRA";
          else if (f7 != 0) ok = 1'b0;
        end
      end
      7'h37: begin e.a = 32'd0; e.b = u; end
      7'h17: begin e.a = pc; e.b = u; end
      7'h03: begin e.a = r1; e.b = 32'(si); end
      7'h23: begin e.a = r1; e.b = 32'(ss); wr = 1'b0; end
      7'h63: begin
        e.a = r1; e.b = r2; wr = 1'b0;
        case (f3)
          0, 1:    m = "SUB";
          4, 5:    m = "SLT";
          6, 7:    m = "SLTU";
          default: ok = 1'b0;
        endcase
      end
      7'h6F: begin e.a = pc; e.b = 32'd4; end
      7'h67: begin e.a = pc; e.b = 32'd4; ok = (f3 == 0); end
      default: ok = 1'b0;
    endcase
    e.rd = ins[11:7];
    if (!ok) begin
      e.a = 32'd0; e.b = 32'd0; e.ctrl = 4'b0000; e.we = 1'b0;
    end else begin
      e.ctrl = code_of(m);
      e.we   = wr && (ins[11:7] != 5'd0);
    end
    e.ill = !ok;
    return e;
  endfunction

  // Compare all outputs against the scoreboard state
  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid_o), 32'(q.size() > 0));
    check("in_ready", 32'(bus.in_ready_o), 32'(q.size() < 2));
    if (q.size() > 0) begin
      check("alu_a", bus.alu_a_o, q[0].a);
      check("alu_b", bus.alu_b_o, q[0].b);
      check("ctrl", 32'(bus.aluctrl_ctrl_o), 32'(q[0].ctrl));
      check("rd", 32'(bus.rd_o), 32'(q[0].rd));
      check("rd_we", 32'(bus.rd_we_o), 32'(q[0].we));
      check("illegal", 32'(bus.illegal_o), 32'(q[0].ill));
    end
    if (was_rst) begin
      check("rst_a", bus.alu_a_o, 32'd0);
      check("rst_b", bus.alu_b_o, 32'd0);
      check("rst_ctrl", 32'(bus.aluctrl_ctrl_o), 32'd0);
      check("rst_rd", 32'(bus.rd_o), 32'd0);
      check("rst_we", 32'(bus.rd_we_o), 32'd0);
      check("rst_ill", 32'(bus.illegal_o), 32'd0);
    end
  endtask

  // Drive one cycle (called just after a falling edge), advance the model,
  // then check at the next falling edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic ordy, input logic fl, input logic rn);
    int cnt;
    cnt = q.size();
    bus.in_valid_i  = v;
    bus.instr_i     = ins;
    bus.pc_i        = pc;
    bus.rs1_data_i  = r1;
    bus.rs2_data_i  = r2;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    rst_n           = rn;
    if (!rn || fl) begin
      q.delete();
    end else begin
      if (cnt > 0 && ordy) void'(q.pop_front());
      if (v && cnt < 2) q.push_back(ref_model(ins, pc, r1, r2));
    end
    was_rst = !rn;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0:  w[6:0] = 7'h33;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h37;
      3:  w[6:0] = 7'h17;
      4:  w[6:0] = 7'h03;
      5:  w[6:0] = 7'h23;
      6:  w[6:0] = 7'h63;
      7:  w[6:0] = 7'h6F;
      8:  w[6:0] = 7'h67;
      9:  w[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[14:12] = 3'b000;
    return w;
  endfunction

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.instr_i     = 32'h0;
    bus.pc_i        = 32'h0;
    bus.rs1_data_i  = 32'h0;
    bus.rs2_data_i  = 32'h0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    rst_n           = 1'b0;
    was_rst         = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // ADD x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    check("add_valid", 32'(bus.out_valid_o), 32'd1);
    check("add_a", bus.alu_a_o, 32'd5);
    check("add_b", bus.alu_b_o, 32'd7);
    check("add_ctrl", 32'(bus.aluctrl_ctrl_o), 32'h0);
    check("add_rd", 32'(bus.rd_o), 32'd3);
    check("add_we", 32'(bus.rd_we_o), 32'd1);

    // SRAI x5,x6,3
    step(1'b1, 32'h40335293, 32'h104, 32'h80000000, 32'h0, 1'b1, 1'b0, 1'b1);
    check("srai_b", bus.alu_b_o, 32'h00000403);
    check("srai_ctrl", 32'(bus.aluctrl_ctrl_o), 32'hD);
    check("srai_rd", 32'(bus.rd_o), 32'd5);

    // LUI x1,0x12345
    step(1'b1, 32'h123450B7, 32'h108, 32'h55, 32'h66, 1'b1, 1'b0, 1'b1);
    check("lui_a", bus.alu_a_o, 32'h0);
    check("lui_b", bus.alu_b_o, 32'h12345000);
    check("lui_ctrl", 32'(bus.aluctrl_ctrl_o), 32'h0);

    // BLTU x1,x2
    step(1'b1, 32'h0020E063, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
    check("bltu_ctrl", 32'(bus.aluctrl_ctrl_o), 32'h3);
    check("bltu_we", 32'(bus.rd_we_o), 32'd0);

    // All-zero word
    step(1'b1, 32'h00000000, 32'h110, 32'h9, 32'h9, 1'b1, 1'b0, 1'b1);
    check("zero_ill", 32'(bus.illegal_o), 32'd1);
    check("zero_a", bus.alu_a_o, 32'd0);
    check("zero_b", bus.alu_b_o, 32'd0);
    check("zero_we", 32'(bus.rd_we_o), 32'd0);

    // OP with funct7=0100000, funct3=111
    step(1'b1, 32'h4020F1B3, 32'h114, 32'h9, 32'h9, 1'b1, 1'b0, 1'b1);
    check("op_alt_ill", 32'(bus.illegal_o), 32'd1);
    idle(1'b1);

    // Backpressure: A then B while stalled
    step(1'b1, 32'h002081B3, 32'h200, 32'd11, 32'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 32'h204, 32'd22, 32'd2, 1'b0, 1'b0, 1'b1);
    check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("bp_hold_a", bus.alu_a_o, 32'd11);
    idle(1'b0);
    check("bp_hold_a2", bus.alu_a_o, 32'd11);
    idle(1'b1);
    check("bp_b_a", bus.alu_a_o, 32'd22);
    check("bp_ready_back", 32'(bus.in_ready_o), 32'd1);
    idle(1'b1);
    check("bp_empty", 32'(bus.out_valid_o), 32'd0);

    // Flush with both entries full; the offered input is dropped
    step(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 32'h304, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 32'h308, 32'd3, 32'd3, 1'b0, 1'b1, 1'b1);
    check("flush_valid", 32'(bus.out_valid_o), 32'd0);
    check("flush_ready", 32'(bus.in_ready_o), 32'd1);
    idle(1'b1);
    check("flush_dropped", 32'(bus.out_valid_o), 32'd0);

    // Reset mid-stall
    step(1'b1, 32'h002081B3, 32'h400, 32'd4, 32'd4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 32'h404, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);
    step(1'b1, 32'h002081B3, 32'h408, 32'd6, 32'd7, 1'b1, 1'b0, 1'b1);
    check("post_rst_a", bus.alu_a_o, 32'd6);
    check("post_rst_valid", 32'(bus.out_valid_o), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
           $urandom_range(0, 99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
